window_seq_ctrl: RTL and testbench

//  Sequencer for the 4-row sliding-window template buffer in the CNN datapath.

---
 rtl/window_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_window_seq_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : window_seq_ctrl
// Description : Sequencer for the sliding-window template buffer: refills the
//               buffer from feature memory, then shifts it out to the PE array.
// Revision    : 1.0 - initial release
// ============================================================================
module window_seq_ctrl #(
    parameter int ROWS          = 4,
    parameter int WORDS_PER_ROW = 4,
    parameter int SHIFTS        = 13,
    parameter int IMG_ROWS      = 16,
    parameter int ADDR_W        = 10
) (
    input  logic              clk,
    input  logic              rstCtrl,
    input  logic              start,
    input  logic [ADDR_W-1:0] baseAddr,
    output logic              memReq,
    output logic [ADDR_W-1:0] memAddr,
    input  logic              memValid,
    output logic              bufRst,
    output logic              bufWE,
    output logic              bufRE,
    input  logic              bufFull,
    input  logic              bufEmpty,
    input  logic              peReady,
    output logic              outValid,
    output logic [4:0]        rowIdx,
    output logic              busy,
    output logic              done,
    output logic              errUnderrun
);

    localparam int         c_FILL_WORDS = ROWS * WORDS_PER_ROW;
    localparam int         c_WC_W       = $clog2(c_FILL_WORDS + 1);
    localparam int         c_SC_W       = $clog2(SHIFTS + 1);
    localparam logic [4:0] c_LAST_ROW   = 5'(IMG_ROWS - ROWS);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_FILL    = 3'd2,
        S_SHIFT   = 3'd3,
        S_ADVANCE = 3'd4,
        S_FINISH  = 3'd5
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [ADDR_W-1:0]   r_ptr;
    logic [ADDR_W-1:0]   r_base;
    logic [4:0]          r_rowIdx;
    logic [c_WC_W-1:0]   r_wordCnt;
    logic [c_SC_W-1:0]   r_shiftCnt;
    logic                r_outValid;
    logic                r_errUnderrun;

    logic                w_write;
    logic                w_read;
    logic                w_lastWord;
    logic                w_shiftsDone;
    logic [ADDR_W-1:0]   w_nextRowBase;

    always_comb begin
        w_write       = (r_state == S_FILL) && memValid && !bufFull;
        w_lastWord    = (r_wordCnt == c_WC_W'(c_FILL_WORDS - 1));
        w_shiftsDone  = (r_shiftCnt == c_SC_W'(SHIFTS));
        // Read decision is state-qualified and gated by the inputs in the same cycle
        w_read        = (r_state == S_SHIFT) && !w_shiftsDone && peReady && !bufEmpty;
        w_nextRowBase = r_base + ADDR_W'((int'(r_rowIdx) + 1) * WORDS_PER_ROW);
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE:    if (start) w_nextState = S_CLEAR;
            S_CLEAR:   w_nextState = S_FILL;
            S_FILL:    if (w_write && w_lastWord) w_nextState = S_SHIFT;
            S_SHIFT: begin
                if (w_shiftsDone)
                    w_nextState = (r_rowIdx == c_LAST_ROW) ? S_FINISH : S_ADVANCE;
                else if (bufEmpty)
                    w_nextState = S_FINISH;
            end
            S_ADVANCE: w_nextState = S_CLEAR;
            S_FINISH:  w_nextState = S_IDLE;
            default:   w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstCtrl) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_base        <= '0;
            r_rowIdx      <= '0;
            r_wordCnt     <= '0;
            r_shiftCnt    <= '0;
            r_outValid    <= 1'b0;
            r_errUnderrun <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_outValid <= w_read;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_base        <= baseAddr;
                        r_ptr         <= baseAddr;
                        r_rowIdx      <= '0;
                        r_errUnderrun <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    r_wordCnt  <= '0;
                    r_shiftCnt <= '0;
                end
                S_FILL: begin
                    if (w_write) begin
                        r_ptr     <= r_ptr + 1'b1;
                        r_wordCnt <= r_wordCnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (w_read)
                        r_shiftCnt <= r_shiftCnt + 1'b1;
                    else if (!w_shiftsDone && bufEmpty)
                        r_errUnderrun <= 1'b1;
                end
                S_ADVANCE: begin
                    // Each row is a full refill from the next image row's start
                    r_rowIdx <= r_rowIdx + 1'b1;
                    r_ptr    <= w_nextRowBase;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        memReq      = (r_state == S_FILL);
        memAddr     = r_ptr;
        bufRst      = (r_state == S_CLEAR);
        bufWE       = w_write;
        bufRE       = w_read;
        outValid    = r_outValid;
        rowIdx      = r_rowIdx;
        busy        = (r_state != S_IDLE);
        done        = (r_state == S_FINISH);
        errUnderrun = r_errUnderrun;
    end

endmodule
`default_nettype wire

// File: tb/tb_window_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_window_seq_ctrl
// Description : Scoreboard bench for window_seq_ctrl with a simple buffer model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_window_seq_ctrl;

    logic       clk = 1'b0;
    logic       rstCtrl = 1'b0;
    logic       start = 1'b0;
    logic [9:0] baseAddr = '0;
    logic       memReq;
    logic [9:0] memAddr;
    logic       memValid = 1'b0;
    logic       bufRst, bufWE, bufRE;
    logic       bufFull, bufEmpty;
    logic       peReady = 1'b0;
    logic       outValid;
    logic [4:0] rowIdx;
    logic       busy, done, errUnderrun;

    int   checks = 0;
    int   failures = 0;
    int   nWE, nRE, nOV, nDone, nRst, rowReads;
    bit   chkRows, chkPe;
    bit   forceEmpty = 1'b0;
    bit   forceFull = 1'b0;
    int   wrCnt = 0;
    int   rdCnt = 0;
    logic [9:0] expAddrQ[$];

    window_seq_ctrl dut (
        .clk(clk), .rstCtrl(rstCtrl), .start(start), .baseAddr(baseAddr),
        .memReq(memReq), .memAddr(memAddr), .memValid(memValid),
        .bufRst(bufRst), .bufWE(bufWE), .bufRE(bufRE),
        .bufFull(bufFull), .bufEmpty(bufEmpty), .peReady(peReady),
        .outValid(outValid), .rowIdx(rowIdx), .busy(busy), .done(done),
        .errUnderrun(errUnderrun)
    );

    always #5 clk = ~clk;

    // Buffer model: full after 16 writes, empty after 13 shifts
    always @(posedge clk) begin
        if (bufRst) begin
            wrCnt <= 0;
            rdCnt <= 0;
        end else begin
            if (bufWE) wrCnt <= wrCnt + 1;
            if (bufRE) rdCnt <= rdCnt + 1;
        end
    end
    assign bufFull  = forceFull || (wrCnt >= 16);
    assign bufEmpty = forceEmpty || (rdCnt >= 13);

    task automatic clear_stats();
        nWE = 0; nRE = 0; nOV = 0; nDone = 0; nRst = 0; rowReads = 0;
    endtask

    task automatic push_run(input logic [9:0] base, input int rows);
        for (int r = 0; r < rows; r++)
            for (int k = 0; k < 16; k++)
                expAddrQ.push_back(base + 10'(r * 4 + k));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rstCtrl = 1'b0; start = 1'b0; memValid = 1'b0; peReady = 1'b0;
        forceEmpty = 1'b0; forceFull = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstCtrl = 1'b1;
    endtask

    task automatic do_start(input logic [9:0] base);
        @(posedge clk); #1;
        baseAddr = base; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic scoreboard_monitor();
        logic       lastPe = 1'b0;
        logic [9:0] exp;
        forever begin
            @(negedge clk);
            if (bufWE) begin
                nWE++;
                checks++;
                if (expAddrQ.size() == 0) begin
                    failures++;
                    $display("FAIL wr_addr: unexpected bufWE at memAddr=%h, none expected", memAddr);
                end else begin
                    exp = expAddrQ.pop_front();
                    if (memAddr !== exp) begin
                        failures++;
                        $display("FAIL wr_addr: memAddr=%h expected=%h", memAddr, exp);
                    end
                end
            end
            if (bufRE) begin
                nRE++;
                rowReads++;
                checks++;
                if (bufWE) begin
                    failures++;
                    $display("FAIL re_we_overlap: bufRE=1 bufWE=%b expected bufWE=0", bufWE);
                end
            end
            if (outValid) begin
                nOV++;
                if (chkPe) begin
                    checks++;
                    if (lastPe !== 1'b1) begin
                        failures++;
                        $display("FAIL outvalid_pe: prev peReady=%b expected 1", lastPe);
                    end
                end
            end
            if (done) nDone++;
            if (bufRst) begin
                if (chkRows) begin
                    checks++;
                    if (rowIdx !== 5'(nRst)) begin
                        failures++;
                        $display("FAIL row_idx: rowIdx=%0d expected=%0d", rowIdx, nRst);
                    end
                    if (nRst != 0) begin
                        checks++;
                        if (rowReads != 13) begin
                            failures++;
                            $display("FAIL row_reads: got=%0d expected=13", rowReads);
                        end
                    end
                end
                nRst++;
                rowReads = 0;
            end
            if (done && chkRows) begin
                checks++;
                if (rowReads != 13) begin
                    failures++;
                    $display("FAIL last_row_reads: got=%0d expected=13", rowReads);
                end
                rowReads = 0;
            end
            lastPe = peReady;
        end
    endtask

    task automatic test_reset();
        chkRows = 0; chkPe = 0;
        do_reset();
        @(negedge clk);
        checks++;
        if ({memReq, bufRst, bufWE, bufRE, outValid, busy, done, errUnderrun} !== 8'h00) begin
            failures++;
            $display("FAIL reset_flags: got=%b expected=00000000",
                     {memReq, bufRst, bufWE, bufRE, outValid, busy, done, errUnderrun});
        end
        checks++;
        if (memAddr !== 10'h000 || rowIdx !== 5'd0) begin
            failures++;
            $display("FAIL reset_regs: memAddr=%h rowIdx=%0d expected 000/0", memAddr, rowIdx);
        end
        do_start(10'h040);
        @(negedge clk);
        checks++;
        if (bufRst !== 1'b1 || busy !== 1'b1 || memReq !== 1'b0) begin
            failures++;
            $display("FAIL clear_state: bufRst=%b busy=%b memReq=%b expected 1/1/0", bufRst, busy, memReq);
        end
        checks++;
        if (memAddr !== 10'h040) begin
            failures++;
            $display("FAIL clear_addr: memAddr=%h expected=040", memAddr);
        end
        @(negedge clk);
        checks++;
        if (bufRst !== 1'b0 || memReq !== 1'b1 || memAddr !== 10'h040) begin
            failures++;
            $display("FAIL fill_entry: bufRst=%b memReq=%b memAddr=%h expected 0/1/040", bufRst, memReq, memAddr);
        end
        do_reset();
    endtask

    task automatic run_to_done(input logic [9:0] base, input bit toggle);
        int guard;
        clear_stats();
        expAddrQ.delete();
        push_run(base, 13);
        memValid = 1'b1; peReady = 1'b1;
        do_start(base);
        guard = 0;
        while (nDone == 0 && guard < 3000) begin
            @(posedge clk); #1;
            guard++;
            if (toggle) begin
                peReady = ~peReady;
                forceFull = ($urandom_range(0, 2) == 0);
            end
        end
        forceFull = 1'b0;
        peReady = 1'b1;
        checks++;
        if (nDone == 0) begin
            failures++;
            $display("FAIL run_timeout: done=0 after %0d cycles expected done", guard);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (nWE != 208 || nRE != 169 || nOV != 169) begin
            failures++;
            $display("FAIL run_counts: WE=%0d RE=%0d OV=%0d expected 208/169/169", nWE, nRE, nOV);
        end
        checks++;
        if (nDone != 1 || nRst != 13) begin
            failures++;
            $display("FAIL run_done: done=%0d rows=%0d expected 1/13", nDone, nRst);
        end
        checks++;
        if (errUnderrun !== 1'b0 || busy !== 1'b0 || expAddrQ.size() != 0) begin
            failures++;
            $display("FAIL run_end: err=%b busy=%b leftover=%0d expected 0/0/0", errUnderrun, busy, expAddrQ.size());
        end
    endtask

    task automatic test_full_run();
        chkRows = 1; chkPe = 0;
        run_to_done(10'h100, 1'b0);
    endtask

    task automatic test_back_pressure();
        chkRows = 1; chkPe = 1;
        run_to_done(10'h200, 1'b1);
        chkPe = 0;
    endtask

    task automatic test_underrun();
        int guard;
        chkRows = 0; chkPe = 0;
        clear_stats();
        expAddrQ.delete();
        push_run(10'h080, 1);
        memValid = 1'b1; peReady = 1'b1;
        do_start(10'h080);
        guard = 0;
        while (nRE < 5 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk); #1;
        forceEmpty = 1'b1;
        guard = 0;
        while (nDone == 0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (nDone != 1) begin
            failures++;
            $display("FAIL underrun_done: done pulses=%0d expected 1", nDone);
        end
        @(negedge clk);
        checks++;
        if (errUnderrun !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL underrun_flag: err=%b busy=%b expected 1/0", errUnderrun, busy);
        end
        checks++;
        if (nRE != 5) begin
            failures++;
            $display("FAIL underrun_reads: got=%0d expected 5", nRE);
        end
        forceEmpty = 1'b0;
    endtask

    task automatic test_wrap();
        chkRows = 1; chkPe = 0;
        clear_stats();
        expAddrQ.delete();
        push_run(10'h3FC, 13);
        memValid = 1'b1; peReady = 1'b1;
        do_start(10'h3FC);
        @(negedge clk);
        checks++;
        if (errUnderrun !== 1'b0 || memAddr !== 10'h3FC) begin
            failures++;
            $display("FAIL wrap_start: err=%b memAddr=%h expected 0/3FC", errUnderrun, memAddr);
        end
        expAddrQ.delete();
        do_reset();
        run_to_done(10'h3FC, 1'b0);
    endtask

    task automatic test_midop_reset();
        int guard;
        chkRows = 0; chkPe = 0;
        clear_stats();
        expAddrQ.delete();
        push_run(10'h0C0, 1);
        memValid = 1'b1; peReady = 1'b1;
        do_start(10'h0C0);
        guard = 0;
        while (nWE < 7 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        rstCtrl = 1'b0; memValid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || memReq !== 1'b0 || memAddr !== 10'h000 || bufWE !== 1'b0) begin
            failures++;
            $display("FAIL midop_reset: busy=%b memReq=%b memAddr=%h bufWE=%b expected 0/0/000/0",
                     busy, memReq, memAddr, bufWE);
        end
        expAddrQ.delete();
        clear_stats();
        push_run(10'h010, 13);
        @(posedge clk); #1;
        rstCtrl = 1'b1; memValid = 1'b1;
        do_start(10'h010);
        @(negedge clk);
        checks++;
        if (bufRst !== 1'b1 || memAddr !== 10'h010 || wrCnt != 7) begin
            failures++;
            $display("FAIL restart_clear: bufRst=%b memAddr=%h modelWords=%0d expected 1/010/7", bufRst, memAddr, wrCnt);
        end
        expAddrQ.delete();
        do_reset();
        chkRows = 1;
        run_to_done(10'h010, 1'b0);
    endtask

    initial begin
        clear_stats();
        chkRows = 0; chkPe = 0;
        fork
            scoreboard_monitor();
        join_none
        test_reset();
        test_full_run();
        test_back_pressure();
        test_underrun();
        test_wrap();
        test_midop_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
